// File: rtl/mac_ctrl_pkg.sv
// mac_ctrl_pkg: shared state encoding, mode codes and default sizing for the MAC job sequencer
package mac_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ISSUE, S_DRAIN, S_DONE} state_e;
  localparam logic MODE_88 = 1'b0;
  localparam logic MODE_18 = 1'b1;
  localparam int MULT_LAT_DEF = 3;
  localparam int LEN_W_DEF = 12;
endpackage

// File: rtl/mac_valid_pipe.sv
// mac_valid_pipe: fire-bit shift register tracking operand pairs in flight through the multiplier
module mac_valid_pipe #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic flush,
  input  logic in_bit,
  output logic out_bit,
  output logic pend
);
  logic [DEPTH-1:0] q_q, q_d;
  always_comb q_d = flush ? '0 : (q_q << 1) | DEPTH'(in_bit);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q_q <= '0;
    else q_q <= q_d;
  assign out_bit = q_q[DEPTH-1];
  // products still in flight behind the one currently being accumulated
  assign pend = |(q_q & ~(DEPTH'(1) << (DEPTH-1)));
endmodule

// File: rtl/mac_dsp_seq_ctrl.sv
// mac_dsp_seq_ctrl: job sequencer streaming operand pairs into a packed-mode DSP MAC PE
module mac_dsp_seq_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int LEN_W    = LEN_W_DEF,
  parameter int A_W      = 24,
  parameter int B_W      = 18,
  parameter int PE_OUT_W = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic                cfg_mode,
  input  logic [LEN_W-1:0]    cfg_len,
  input  logic                abort,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [A_W-1:0]      in_a,
  input  logic [B_W-1:0]      in_b,
  output logic                mac_en,
  output logic                mac_clr,
  output logic                mac_mode,
  output logic [A_W-1:0]      mac_a,
  output logic [B_W-1:0]      mac_b,
  input  logic [PE_OUT_W-1:0] mac_o,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PE_OUT_W-1:0] out_data,
  output logic                busy
);
  state_e state_q, state_d;
  logic mode_q, mode_d, mac_clr_q, mac_clr_d;
  logic [LEN_W-1:0] len_q, len_d, issued_q, issued_d;
  logic start_fire, in_fire, flush, pend;
  assign start_ready = state_q == S_IDLE;
  assign start_fire  = start_valid && start_ready;
  assign busy        = state_q != S_IDLE;
  assign flush       = abort && busy;
  assign in_ready    = state_q == S_ISSUE && issued_q < len_q && !abort;
  assign in_fire     = in_valid && in_ready;
  assign mac_a       = in_fire ? in_a : '0;
  assign mac_b       = in_fire ? in_b : '0;
  assign mac_mode    = mode_q;
  assign mac_clr     = mac_clr_q;
  // an abort in DONE suppresses the result even if the consumer is ready
  assign out_valid   = state_q == S_DONE && !abort;
  assign out_data    = out_valid ? mac_o : '0;
  mac_valid_pipe #(.DEPTH(MULT_LAT)) u_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .in_bit  (in_fire),
    .out_bit (mac_en),
    .pend    (pend)
  );
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    len_d    = len_q;
    issued_d = issued_q + LEN_W'(in_fire);
    if (flush) state_d = S_IDLE;
    else
      case (state_q)
        S_IDLE: if (start_fire) begin
          state_d  = S_CLEAR;
          mode_d   = cfg_mode;
          len_d    = cfg_len;
          issued_d = '0;
        end
        S_CLEAR: state_d = len_q == '0 ? S_DRAIN : S_ISSUE;
        S_ISSUE: state_d = in_fire && issued_q + LEN_W'(1) == len_q ? S_DRAIN : S_ISSUE;
        S_DRAIN: state_d = pend ? S_DRAIN : S_DONE;
        S_DONE:  state_d = out_ready ? S_IDLE : S_DONE;
        default: state_d = S_IDLE;
      endcase
    mac_clr_d = state_d == S_CLEAR;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q   <= S_IDLE;
      mode_q    <= MODE_88;
      len_q     <= '0;
      issued_q  <= '0;
      mac_clr_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      mac_clr_q <= mac_clr_d;
    end
endmodule

// File: tb/tb_mac_dsp_seq_ctrl.sv
// tb_mac_dsp_seq_ctrl: directed jobs against the sequencer driving a small packed-lane MAC model
module tb_mac_dsp_seq_ctrl;
  logic clk = 1'b0;
  logic reset_n, start_valid, start_ready, cfg_mode, abort, in_valid, in_ready;
  logic [11:0] cfg_len;
  logic [23:0] in_a, mac_a;
  logic [17:0] in_b, mac_b;
  logic mac_en, mac_clr, mac_mode, out_valid, out_ready, busy;
  logic [63:0] mac_o, out_data;
  int checks = 0, errors = 0, vi;
  logic [23:0] va [16];
  logic [17:0] vb [16];
  logic [31:0] en_m, ov_m, clr_m, fire_m, sr_m, busy_m, mode_m;
  logic [63:0] od_c [32];
  always #5 clk = ~clk;
  mac_dsp_seq_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start_valid(start_valid), .start_ready(start_ready),
    .cfg_mode(cfg_mode), .cfg_len(cfg_len), .abort(abort), .in_valid(in_valid),
    .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .mac_en(mac_en), .mac_clr(mac_clr),
    .mac_mode(mac_mode), .mac_a(mac_a), .mac_b(mac_b), .mac_o(mac_o), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );
  // MAC model: mode0 = two 24b lanes (pixel byte x signed 9b weight), mode1 = four 16b lanes (6b pixel x shared weight)
  function automatic logic [63:0] lane_add(logic m, logic [63:0] acc, logic [23:0] a, logic [17:0] b);
    logic [63:0] r;
    r = acc;
    if (m)
      for (int i = 0; i < 4; i++)
        r[16*i+:16] = acc[16*i+:16] + 16'($signed({1'b0, a[6*i+:6]}) * $signed(b[8:0]));
    else begin
      r[23:0]  = acc[23:0]  + 24'($signed({1'b0, a[7:0]})  * $signed(b[8:0]));
      r[47:24] = acc[47:24] + 24'($signed({1'b0, a[15:8]}) * $signed(b[17:9]));
    end
    return r;
  endfunction
  logic [23:0] pa [3];
  logic [17:0] pb [3];
  logic [63:0] acc;
  always_ff @(posedge clk) begin
    pa[0] <= mac_a; pa[1] <= pa[0]; pa[2] <= pa[1];
    pb[0] <= mac_b; pb[1] <= pb[0]; pb[2] <= pb[1];
    if (mac_clr) acc <= '0;
    else if (mac_en) acc <= lane_add(mac_mode, acc, pa[2], pb[2]);
  end
  assign mac_o = acc;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // one job window starting at posedge+1 of cycle 0; cfg is only correct while start_valid is high
  task automatic run_job(input logic m, input logic [11:0] l, input int n,
                         input logic [31:0] sv, input logic [31:0] iv,
                         input logic [31:0] ab, input logic [31:0] rdy);
    en_m = '0; ov_m = '0; clr_m = '0; fire_m = '0; sr_m = '0; busy_m = '0; mode_m = '0;
    for (int c = 0; c < n; c++) begin
      start_valid = sv[c];
      cfg_mode    = sv[c] ? m : ~m;
      cfg_len     = sv[c] ? l : l + 12'd5;
      in_valid    = iv[c];
      abort       = ab[c];
      out_ready   = rdy[c];
      in_a        = va[vi];
      in_b        = vb[vi];
      @(negedge clk);
      en_m[c] = mac_en; ov_m[c] = out_valid; clr_m[c] = mac_clr; sr_m[c] = start_ready;
      busy_m[c] = busy; mode_m[c] = mac_mode; fire_m[c] = in_valid && in_ready;
      od_c[c] = out_data;
      if (in_valid && in_ready) vi++;
      @(posedge clk); #1;
    end
    start_valid = 0; in_valid = 0; abort = 0; out_ready = 0;
  endtask
  initial begin
    reset_n = 0; start_valid = 0; cfg_mode = 0; cfg_len = 0; abort = 0;
    in_valid = 0; in_a = 0; in_b = 0; out_ready = 0; vi = 0;
    for (int i = 0; i < 16; i++) begin va[i] = '0; vb[i] = '0; end
    repeat (2) @(posedge clk);
    #2 chk("rst_outs", {busy, mac_en, mac_clr, mac_mode, out_valid, start_ready, in_ready}, 7'b0010010);
    @(negedge clk) reset_n = 1;
    #1 chk("rst_clr_hold", mac_clr, 1);
    @(posedge clk); #1 chk("rst_clr_drop", mac_clr, 0);
    // 1: mode1 len4, continuous in_valid
    for (int i = 0; i < 4; i++) va[i] = 24'h103081;
    vb[0] = 18'h1; vb[1] = 18'h2; vb[2] = 18'h3; vb[3] = 18'h1FF; vi = 0;
    run_job(1, 4, 12, 32'h1, 32'hFFFF_FFFE, 0, 32'h200);
    chk("t1_fire", fire_m, 32'h3C);
    chk("t1_en", en_m, 32'h1E0);
    chk("t1_ov", ov_m, 32'h200);
    chk("t1_clr", clr_m, 32'h2);
    chk("t1_busy", busy_m, 32'h3FE);
    chk("t1_data", od_c[9], 64'h0014_000F_000A_0005);
    // 2: mode0 len3, bubble at cycle 3
    for (int i = 0; i < 3; i++) va[i] = 24'h000302;
    vb[0] = 18'h00401; vb[1] = 18'h003FD; vb[2] = 18'h3FE04; vi = 0;
    run_job(0, 3, 12, 32'h1, ~32'h8, 0, 32'h200);
    chk("t2_fire", fire_m, 32'h34);
    chk("t2_en", en_m, 32'h1A0);
    chk("t2_ov", ov_m, 32'h200);
    chk("t2_mode", mode_m[11:0], 12'h001);
    chk("t2_data", od_c[9], 64'h0000_0000_0600_0004);
    // 3: result held 10 cycles with start_valid pending, then start accepted in next IDLE
    for (int i = 0; i < 4; i++) va[i] = 24'h041041;
    vb[0] = 18'h1; vb[1] = 18'h2; vb[2] = 18'h5; vb[3] = 18'h1FF; vi = 0;
    run_job(1, 2, 27, 32'h7FF81, 32'hFFFF_FFFF, 0, 32'h602_0000);
    chk("t3_ov", ov_m, 32'h203_FF80);
    chk("t3_en", en_m, 32'h180_0060);
    chk("t3_clr", clr_m, 32'h8_0002);
    chk("t3_sready", sr_m, 32'h404_0001);
    chk("t3_data_first", od_c[7], 64'h0003_0003_0003_0003);
    chk("t3_data_hold", od_c[16], 64'h0003_0003_0003_0003);
    chk("t3_data_last", od_c[17], 64'h0003_0003_0003_0003);
    chk("t3_data_job2", od_c[25], 64'h0004_0004_0004_0004);
    // 4: abort at cycle 4 of a len8 job, then a len1 job sees only its own product
    va[0] = 24'h000101; va[1] = 24'h000101; vb[0] = 18'h401; vb[1] = 18'h401;
    va[2] = 24'h000504; vb[2] = 18'h3FC03; vi = 0;
    run_job(0, 8, 10, 32'h1, 32'hFFFF_FFFF, 32'h10, 0);
    chk("t4_fire", fire_m, 32'hC);
    chk("t4_en", en_m, 32'h0);
    chk("t4_ov", ov_m, 32'h0);
    chk("t4_busy", busy_m, 32'h1E);
    chk("t4_sready", sr_m, 32'h3E1);
    run_job(0, 1, 8, 32'h1, 32'hFFFF_FFFF, 0, 32'h40);
    chk("t4b_en", en_m, 32'h20);
    chk("t4b_ov", ov_m, 32'h40);
    chk("t4b_data", od_c[6], 64'h0000_FFFF_F600_000C);
    // 5: len0 jobs of alternating mode back to back
    run_job(1, 0, 5, 32'h1, 0, 0, 32'h8);
    chk("t5_clr", clr_m, 32'h2);
    chk("t5_ov", ov_m, 32'h8);
    chk("t5_busy", busy_m, 32'hE);
    chk("t5_data", od_c[3], 64'h0);
    chk("t5_mode", mode_m, 32'h1E);
    run_job(0, 0, 5, 32'h1, 0, 0, 32'h8);
    chk("t5b_ov", ov_m, 32'h8);
    chk("t5b_mode", mode_m, 32'h01);
    // 6: async reset in the middle of ISSUE
    for (int i = 0; i < 8; i++) begin va[i] = 24'h041041; vb[i] = 18'h1; end
    vi = 0;
    run_job(1, 8, 5, 32'h1, 32'hFFFF_FFFF, 0, 0);
    #2 chk("t6_pre", {busy, mac_en, mac_mode}, 3'b111);
    reset_n = 0;
    #1 chk("t6_async", {busy, mac_en, mac_clr, mac_mode, out_valid, start_ready, in_ready}, 7'b0010010);
    @(posedge clk); #3 reset_n = 1;
    #1 chk("t6_clr_hold", mac_clr, 1);
    @(posedge clk); #1 chk("t6_clr_drop", {mac_clr, busy}, 2'b00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
